// File: rtl/ps2_key_receiver.sv
// PS/2 set-2 receiver: frames bytes off the raw PS/2 pins and tracks W/A/S/D make/break
// events, presenting the currently held key as ASCII plus a held bitmap.
module ps2_key_receiver #(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int TO_W           = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key,
   output logic       key_strobe,
   output logic [3:0] keys_held,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   localparam logic [7:0] BYTE_BRK = 8'hF0;
   localparam logic [7:0] BYTE_EXT = 8'hE0;

   // Odd parity holds when data plus parity carry an odd number of ones.
   function automatic logic parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

   // Map a set-2 scan code onto its {w,a,s,d} bit; zero means unmapped.
   function automatic logic [3:0] code_mask(input logic [7:0] code);
      logic [3:0] m;
      case (code)
         8'h1D:   m = 4'b1000;
         8'h1C:   m = 4'b0100;
         8'h1B:   m = 4'b0010;
         8'h23:   m = 4'b0001;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Highest-priority (w>a>s>d) set bit of the mask as ASCII, 8'h00 when empty.
   function automatic logic [7:0] mask_ascii(input logic [3:0] m);
      logic [7:0] a;
      if (m[3]) begin
         a = 8'h77;
      end else if (m[2]) begin
         a = 8'h61;
      end else if (m[1]) begin
         a = 8'h73;
      end else if (m[0]) begin
         a = 8'h64;
      end else begin
         a = 8'h00;
      end
      return a;
   endfunction

   logic            ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
   logic            ps2d_meta_q, ps2d_sync_q;
   logic            fall_s;
   logic            timeout_s;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            byte_vld_q, byte_vld_d;
   logic [7:0]      byte_q, byte_d;
   logic            frame_err_q, frame_err_d;

   logic            brk_q, brk_d;
   logic            ext_q, ext_d;
   logic [3:0]      held_q, held_d;
   logic [7:0]      key_q, key_d;
   logic            strobe_q, strobe_d;
   logic [3:0]      mask_s;

   // Two-flop synchronizers on both PS/2 lines, plus the previous clock sample for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps2c_meta_q <= 1'b1;
         ps2c_sync_q <= 1'b1;
         ps2c_prev_q <= 1'b1;
         ps2d_meta_q <= 1'b1;
         ps2d_sync_q <= 1'b1;
      end else begin
         ps2c_meta_q <= ps2_clk;
         ps2c_sync_q <= ps2c_meta_q;
         ps2c_prev_q <= ps2c_sync_q;
         ps2d_meta_q <= ps2_data;
         ps2d_sync_q <= ps2d_meta_q;
      end
   end

   assign fall_s    = ps2c_prev_q & ~ps2c_sync_q;
   assign timeout_s = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Frame state register and the accepted-byte handoff to the decoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         to_cnt_q    <= '0;
         byte_vld_q  <= 1'b0;
         byte_q      <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         to_cnt_q    <= to_cnt_d;
         byte_vld_q  <= byte_vld_d;
         byte_q      <= byte_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Frame FSM; a PS/2 edge takes precedence over a timeout landing in the same cycle.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      to_cnt_d    = to_cnt_q;
      byte_vld_d  = 1'b0;
      byte_d      = byte_q;
      frame_err_d = 1'b0;
      if (fall_s) begin
         to_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!ps2d_sync_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d   = {ps2d_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               parity_d = ps2d_sync_q;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               if (ps2d_sync_q && parity_ok({shift_q, parity_q})) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (timeout_s) begin
         state_d     = ST_IDLE;
         frame_err_d = 1'b1;
         to_cnt_d    = '0;
      end else if (state_q != ST_IDLE) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
         to_cnt_d = '0;
      end
   end

   // Decoder state: prefix flags, held bitmap and the presented key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk_q    <= 1'b0;
         ext_q    <= 1'b0;
         held_q   <= 4'b0000;
         key_q    <= 8'h00;
         strobe_q <= 1'b0;
      end else begin
         brk_q    <= brk_d;
         ext_q    <= ext_d;
         held_q   <= held_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
      end
   end

   assign mask_s = code_mask(byte_q);

   // Make/break decode; a released key that is not the one shown leaves key untouched.
   always_comb begin
      brk_d    = brk_q;
      ext_d    = ext_q;
      held_d   = held_q;
      key_d    = key_q;
      strobe_d = 1'b0;
      if (byte_vld_q) begin
         if (byte_q == BYTE_BRK) begin
            brk_d = 1'b1;
         end else if (byte_q == BYTE_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q && (mask_s != 4'b0000)) begin
               if (!brk_q) begin
                  held_d   = held_q | mask_s;
                  key_d    = mask_ascii(mask_s);
                  strobe_d = 1'b1;
               end else begin
                  held_d = held_q & ~mask_s;
                  if (key_q == mask_ascii(mask_s)) begin
                     key_d    = mask_ascii(held_q & ~mask_s);
                     strobe_d = 1'b1;
                  end else begin
                     key_d = key_q;
                  end
               end
            end else begin
               held_d = held_q;
            end
         end
      end else begin
         strobe_d = 1'b0;
      end
   end

   assign key        = key_q;
   assign key_strobe = strobe_q;
   assign keys_held  = held_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: stimulus pushes expected strobes/errors,
// a negedge monitor pops and compares whenever the DUT pulses key_strobe or frame_err.
module tb_ps2_key_receiver;

   localparam int TO   = 300;
   localparam int HALF = 20;

   typedef struct packed {
      logic [7:0] key;
      logic [3:0] held;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] key;
   logic       key_strobe;
   logic [3:0] keys_held;
   logic       frame_err;

   exp_t exp_q[$];
   int   err_pending = 0;
   int   checks = 0;
   int   errors = 0;

   ps2_key_receiver #(.TIMEOUT_CYCLES(TO), .TO_W(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key        (key),
      .key_strobe (key_strobe),
      .keys_held  (keys_held),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic push(input logic [7:0] k, input logic [3:0] h);
      exp_t e;
      e.key  = k;
      e.held = h;
      exp_q.push_back(e);
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Full frame; lat=1 also checks key is old 3 clocks after the stop edge and new after 4.
   task automatic send_byte(input logic [7:0] b, input logic bad, input logic lat,
                            input logic [7:0] pre, input logic [7:0] post);
      logic p;
      p = ~(^b) ^ bad;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      if (lat) begin
         @(negedge clk);
         ps2_data = 1'b1;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(posedge clk);
         #1 chk("latency_before", {4'h0, key}, {4'h0, pre});
         @(posedge clk);
         #1 chk("latency_after", {4'h0, key}, {4'h0, post});
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end else begin
         ps2_bit(1'b1);
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_byte(b, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic check_state(input string name, input logic [7:0] k, input logic [3:0] h);
      @(negedge clk);
      chk(name, {key, keys_held}, {k, h});
   endtask

   // Monitor: every strobe/error pulse must match the next expectation in order.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (key_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: key %h held %b, none expected", key, keys_held);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("strobe_value", {key, keys_held}, {e.key, e.held});
            end
         end
         if (frame_err === 1'b1) begin
            chk("frame_err_expected", {11'd0, err_pending > 0}, 12'd1);
            if (err_pending > 0) err_pending--;
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_key", {4'h0, key}, 12'h000);
      chk("reset_held", {8'h00, keys_held}, 12'h000);
      chk("reset_strobe", {11'd0, key_strobe}, 12'd0);
      chk("reset_err", {11'd0, frame_err}, 12'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Make W with latency check, then release.
      push(8'h77, 4'b1000);
      send_byte(8'h1D, 1'b0, 1'b1, 8'h00, 8'h77);
      check_state("make_w", 8'h77, 4'b1000);
      push(8'h00, 4'b0000);
      send(8'hF0); send(8'h1D);
      check_state("break_w", 8'h00, 4'b0000);

      // Overlap A then D, release D.
      push(8'h61, 4'b0100); send(8'h1C);
      push(8'h64, 4'b0101); send(8'h23);
      push(8'h61, 4'b0100); send(8'hF0); send(8'h23);
      check_state("overlap", 8'h61, 4'b0100);
      push(8'h00, 4'b0000); send(8'hF0); send(8'h1C);

      // Break of a key not currently shown.
      push(8'h73, 4'b0010); send(8'h1B);
      push(8'h77, 4'b1010); send(8'h1D);
      send(8'hF0); send(8'h1B);
      check_state("break_noncurrent", 8'h77, 4'b1000);
      push(8'h00, 4'b0000); send(8'hF0); send(8'h1D);
      check_state("break_last", 8'h00, 4'b0000);

      // Parity error leaves state alone; next frame decodes; break falls back to A.
      push(8'h61, 4'b0100); send(8'h1C);
      err_pending++;
      send_byte(8'h1D, 1'b1, 1'b0, 8'h00, 8'h00);
      check_state("parity_err", 8'h61, 4'b0100);
      push(8'h77, 4'b1100); send(8'h1D);
      push(8'h61, 4'b0100); send(8'hF0); send(8'h1D);
      push(8'h00, 4'b0000); send(8'hF0); send(8'h1C);

      // Extended and unmapped codes; F0 on unmapped clears brk.
      send(8'hE0); send(8'h1D);
      check_state("extended", 8'h00, 4'b0000);
      send(8'h15);
      send(8'hF0); send(8'h15);
      push(8'h77, 4'b1000); send(8'h1D);
      check_state("brk_cleared", 8'h77, 4'b1000);
      push(8'h77, 4'b1000); send(8'h1D);
      push(8'h00, 4'b0000); send(8'hF0); send(8'h1D);

      // Timeout after 4 data bits.
      err_pending++;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TO + 50) @(negedge clk);
      chk("timeout_seen", {11'd0, err_pending == 0}, 12'd1);
      push(8'h61, 4'b0100); send(8'h1C);
      check_state("after_timeout", 8'h61, 4'b0100);

      // Reset mid-frame.
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_key", {4'h0, key}, 12'h000);
      chk("midrst_held", {8'h00, keys_held}, 12'h000);
      chk("midrst_strobe", {11'd0, key_strobe}, 12'd0);
      repeat (5) @(negedge clk);
      ps2_data = 1'b1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      push(8'h61, 4'b0100); send(8'h1C);
      check_state("after_reset", 8'h61, 4'b0100);

      repeat (10) @(negedge clk);
      chk("strobe_queue_empty", 12'(exp_q.size()), 12'd0);
      chk("err_pending_zero", 12'(err_pending), 12'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Receives PS/2 keyboard frames and decodes set-2 scan codes for W/A/S/D into the ASCII key byte consumed by the motion control logic.
- Tracks press (make) and release (break, F0 prefix) so the key byte reflects the currently held key.
- Also exports a held-key bitmap and a one-cycle strobe per make or break event.
- Sits between the board PS/2 pins and the key-to-motion mapping block.

Parameters:
- TIMEOUT_CYCLES, 10000, system clocks without a PS/2 falling edge before a partial frame is aborted.
- TO_W, 14, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- key  out  8  ASCII of the most recently pressed mapped key still held; 8'h00 when none.
- key_strobe  out  1  one-cycle pulse when key changes due to a make or break.
- keys_held  out  4  {w,a,s,d} held bitmap.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset (async, rst_n=0): key=8'h00, key_strobe=0, keys_held=4'b0, frame_err=0, FSM=IDLE, prefix flags cleared, synchronizers=1.
- Synchronization: ps2_clk and ps2_data each pass through 2 flops. A falling edge is prev_sync=1, sync=0. Data is sampled on the same cycle the edge is detected.
- FSM states (all on falling edge unless noted):
  - IDLE: data=0 goes to DATA with bit count 0. Data=1 stays in IDLE and pulses frame_err.
  - DATA: shift 8 bits LSB first. Go to PARITY after bit 7.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if data=1 and the 9 bits (data plus parity) have odd ones-count, the byte is accepted; otherwise frame_err pulses. Either way, return to IDLE.
- Timeout: counter resets on each falling edge and counts only when FSM≠IDLE. Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE, pulses frame_err, and discards the partial byte. Prefix flags are kept.
- Decode: performed the cycle after a byte is accepted, so outputs update 2 clocks after the stop-bit edge is detected.
  - Byte F0: set brk.
  - Byte E0: set ext.
  - Any other byte: it is a code. brk and ext both clear after a code byte.
  - Code with ext=1: ignored (no output change).
  - Mapped codes: 1D→'w'(8'h77, bit3), 1C→'a'(8'h61, bit2), 1B→'s'(8'h73, bit1), 23→'d'(8'h64, bit0). Unmapped codes are ignored.
  - Make (brk=0) of a mapped code: set its keys_held bit, key=ascii, key_strobe=1. Typematic repeats strobe again with the same key.
  - Break (brk=1) of a mapped code: clear its bit, then:
    - if key equals that ascii, key becomes the remaining held key with highest priority w>a>s>d, or 8'h00 if none; strobe=1.
    - otherwise key is unchanged and strobe=0.
- Simultaneous events: a timeout and an edge in the same cycle resolve as edge wins (counter reset, edge processed). A frame error never alters key or keys_held.
- Reset mid-frame: everything returns to reset values immediately; the next frame must begin with a start bit.

Test Plan:
- Make 'W': frame 0x1D (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) → key=8'h77, keys_held=4'b1000, one key_strobe, 2 clocks after the stop edge.
- Overlap: make A (1C), make D (23), then F0 23 → key goes 8'h61 → 8'h64 → 8'h61. keys_held goes 0100 → 0101 → 0100. Three strobes.
- Break non-current key: make S, make W, then F0 1B → key stays 8'h77, keys_held=1000, no strobe. Then F0 1D → key=8'h00 with a strobe.
- Parity error: 0x1D sent with parity 0 → frame_err pulse; key and keys_held unchanged. The next valid frame decodes normally.
- Extended/unmapped: E0 1D → no change. 0x15 → no change. F0 15 → no change, and brk is cleared (a following 1D is a make).
- Timeout/reset: stop toggling after 4 data bits for TIMEOUT_CYCLES → frame_err pulse, FSM in IDLE, next full 0x1C frame yields 8'h61. Asserting rst_n low mid-frame → all outputs 0 immediately.
